// File: rtl/wb_cmd_bridge.sv
// Byte-stream command parser in front of the wishbone master: decodes framed
// read/write commands, launches one transfer per frame and streams back status plus read data.
module wb_cmd_bridge #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int MAX_PAYLOAD   = 8,
  parameter int LEN_N         = 3,
  parameter int RX_TIMEOUT    = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [ADDRESS_WIDTH-1:0]   transfer_address,
  output logic [8*MAX_PAYLOAD-1:0]   payload_out,
  input  logic [8*MAX_PAYLOAD-1:0]   payload_in,
  output logic [LEN_N-1:0]           payload_length,
  output logic                       start_read,
  output logic                       start_write,
  input  logic                       read_busy,
  input  logic                       write_busy,
  input  logic                       completed,
  input  logic                       timeout,
  output logic                       frame_error
);

  localparam int MAX_LEN = (MAX_PAYLOAD < (2**LEN_N - 1)) ? MAX_PAYLOAD : (2**LEN_N - 1);
  localparam int TW      = $clog2(RX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA, S_ISSUE, S_WAIT, S_RESP_STAT, S_RESP_DATA
  } state_t;

  state_t                     state_q, state_d;
  logic                       wr_q;
  logic [3:0]                 len_q;
  logic [LEN_N-1:0]           k_q;
  logic [7:0]                 status_q;
  logic [TW-1:0]              tmo_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [8*MAX_PAYLOAD-1:0]   payload_q;
  logic [LEN_N-1:0]           plen_q;
  logic                       tx_valid_q;
  logic [7:0]                 tx_data_q;
  logic                       frame_error_q;

  logic       in_frame, rx_fire, tx_fire, rx_abort, len_ok, last_lane, master_done;
  logic [3:0] k_next;
  logic [2:0] rsvd_unused;

  assign rsvd_unused = rx_data[6:4];
  assign in_frame    = (state_q == S_ADDR_HI) || (state_q == S_ADDR_LO) || (state_q == S_DATA);
  assign rx_fire     = rx_valid && rx_ready;
  assign tx_fire     = tx_valid_q && tx_ready;
  assign rx_abort    = in_frame && !rx_fire && (tmo_q == TW'(RX_TIMEOUT - 1));
  assign len_ok      = (len_q != 4'd0) && (len_q <= 4'(MAX_LEN));
  assign k_next      = 4'(k_q) + 4'd1;
  assign last_lane   = (k_next == len_q);
  assign master_done = !read_busy && !write_busy && (completed || timeout);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_CMD;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CMD:       if (rx_fire) state_d = S_ADDR_HI;
      S_ADDR_HI: begin
        if (rx_fire)       state_d = S_ADDR_LO;
        else if (rx_abort) state_d = S_CMD;
      end
      S_ADDR_LO: begin
        if (rx_fire) begin
          if (!len_ok)   state_d = S_RESP_STAT;
          else if (wr_q) state_d = S_DATA;
          else           state_d = S_ISSUE;
        end else if (rx_abort) begin
          state_d = S_CMD;
        end
      end
      S_DATA: begin
        if (rx_fire && last_lane) state_d = S_ISSUE;
        else if (rx_abort)        state_d = S_CMD;
      end
      S_ISSUE:     state_d = S_WAIT;
      S_WAIT:      if (master_done) state_d = S_RESP_STAT;
      S_RESP_STAT: begin
        if (tx_fire) state_d = (status_q == 8'h00 && !wr_q) ? S_RESP_DATA : S_CMD;
      end
      S_RESP_DATA: if (tx_fire && last_lane) state_d = S_CMD;
      default:     state_d = S_CMD;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    rx_ready    = in_frame || (state_q == S_CMD);
    start_write = (state_q == S_ISSUE) && wr_q;
    start_read  = (state_q == S_ISSUE) && !wr_q;
    if (rst_i) rx_ready = 1'b0;
  end

  // Frame capture, response sequencing and idle-timeout datapath
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q          <= 1'b0;
      len_q         <= '0;
      k_q           <= '0;
      status_q      <= '0;
      tmo_q         <= '0;
      addr_q        <= '0;
      payload_q     <= '0;
      plen_q        <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      frame_error_q <= 1'b0;
    end else begin
      frame_error_q <= rx_abort;
      if (rx_fire || !in_frame) tmo_q <= '0;
      else                      tmo_q <= tmo_q + 1'b1;

      case (state_q)
        S_CMD: if (rx_fire) begin
          wr_q  <= rx_data[7];
          len_q <= rx_data[3:0];
          k_q   <= '0;
        end
        S_ADDR_HI: if (rx_fire) addr_q[15:8] <= rx_data;
        S_ADDR_LO: if (rx_fire) begin
          addr_q[7:0] <= rx_data;
          if (!len_ok) status_q <= 8'h02;
        end
        S_DATA: if (rx_fire) begin
          payload_q[8*k_q +: 8] <= rx_data;
          k_q                   <= k_q + 1'b1;
        end
        S_WAIT: if (master_done) begin
          status_q <= timeout ? 8'h01 : 8'h00;
          k_q      <= '0;
        end
        S_RESP_STAT, S_RESP_DATA: begin
          // Each byte is loaded once, held until taken, then the slot empties for a cycle
          if (tx_fire) begin
            tx_valid_q <= 1'b0;
            if (state_q == S_RESP_DATA) k_q <= k_q + 1'b1;
          end else if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= (state_q == S_RESP_STAT) ? status_q : payload_in[8*k_q +: 8];
          end
        end
        default: ;
      endcase

      if (state_d == S_ISSUE) plen_q <= len_q[LEN_N-1:0];
    end
  end

  assign tx_valid         = tx_valid_q;
  assign tx_data          = tx_data_q;
  assign transfer_address = addr_q;
  assign payload_out      = payload_q;
  assign payload_length   = plen_q;
  assign frame_error      = frame_error_q;

endmodule

// File: tb/tb_wb_cmd_bridge.sv
// Directed bench for wb_cmd_bridge: drives command frames, plays the wishbone master
// handshake by hand and checks responses against hand-computed values.
module tb_wb_cmd_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] transfer_address;
  logic [63:0] payload_out;
  logic [63:0] payload_in;
  logic [2:0]  payload_length;
  logic        start_read, start_write;
  logic        read_busy, write_busy, completed, timeout;
  logic        frame_error;

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;

  wb_cmd_bridge dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .transfer_address(transfer_address), .payload_out(payload_out), .payload_in(payload_in),
    .payload_length(payload_length), .start_read(start_read), .start_write(start_write),
    .read_busy(read_busy), .write_busy(write_busy), .completed(completed), .timeout(timeout),
    .frame_error(frame_error)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (start_read || start_write) n_starts <= n_starts + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin @(negedge clk_i); n++; end
    chk("rx_accept", rx_ready, 1'b1);
    @(negedge clk_i);
    rx_valid = 1'b0;
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a); send_byte(b); send_byte(c);
  endtask

  task automatic recv_byte(output logic [7:0] b);
    int n = 0;
    tx_ready = 1'b1;
    while (!tx_valid && n < 200) begin @(negedge clk_i); n++; end
    chk("tx_seen", tx_valid, 1'b1);
    b = tx_data;
    @(negedge clk_i);
    tx_ready = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!(start_read || start_write) && n < 100) begin @(negedge clk_i); n++; end
    chk("start_seen", start_read || start_write, 1'b1);
  endtask

  // Master side: go busy on the start cycle, finish a few cycles later
  task automatic master_run(input logic to);
    if (start_write) write_busy = 1'b1; else read_busy = 1'b1;
    completed = 1'b0;
    timeout   = 1'b0;
    @(negedge clk_i);
    chk("start_one_cycle", {start_read, start_write}, 2'b00);
    chk("rx_ready_busy", rx_ready, 1'b0);
    repeat (3) @(negedge clk_i);
    read_busy  = 1'b0;
    write_busy = 1'b0;
    completed  = !to;
    timeout    = to;
  endtask

  initial begin
    logic [7:0] b, held;
    int         s0;
    bit         stable;

    rst_i = 1'b1; rx_data = '0; rx_valid = 1'b0; tx_ready = 1'b0; payload_in = '0;
    read_busy = 1'b0; write_busy = 1'b0; completed = 1'b0; timeout = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_starts", {start_read, start_write, frame_error}, 3'b000);
    chk("rst_addr", transfer_address, 16'h0000);
    chk("rst_payload", payload_out, 64'h0);
    chk("rst_len", payload_length, 3'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle_rx_ready", rx_ready, 1'b1);

    // Write of one byte
    send3(8'h81, 8'h12, 8'h34);
    send_byte(8'hAA);
    wait_start();
    chk("wr_kind", {start_read, start_write}, 2'b01);
    chk("wr_addr", transfer_address, 16'h1234);
    chk("wr_len", payload_length, 3'd1);
    chk("wr_lane0", payload_out[7:0], 8'hAA);
    master_run(1'b0);
    recv_byte(b);
    chk("wr_status", b, 8'h00);
    @(negedge clk_i);
    chk("wr_no_more_tx", tx_valid, 1'b0);
    chk("wr_back_cmd", rx_ready, 1'b1);

    // Read of three bytes, with backpressure on the second data byte
    send3(8'h03, 8'h00, 8'h10);
    wait_start();
    chk("rd_kind", {start_read, start_write}, 2'b10);
    chk("rd_addr", transfer_address, 16'h0010);
    chk("rd_len", payload_length, 3'd3);
    payload_in = 64'h0000_0000_0033_2211;
    master_run(1'b0);
    recv_byte(b); chk("rd_status", b, 8'h00);
    recv_byte(b); chk("rd_d0", b, 8'h11);
    s0 = 0;
    while (!tx_valid && s0 < 50) begin @(negedge clk_i); s0++; end
    held   = tx_data;
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk_i);
      if (!tx_valid || tx_data !== held) stable = 1'b0;
    end
    chk("bp_stable", stable, 1'b1);
    chk("bp_held", held, 8'h22);
    recv_byte(b); chk("rd_d1", b, 8'h22);
    recv_byte(b); chk("rd_d2", b, 8'h33);
    repeat (3) @(negedge clk_i);
    chk("rd_no_more_tx", tx_valid, 1'b0);
    chk("rd_back_cmd", rx_ready, 1'b1);

    // Illegal lengths 0 and 8 answer 02 with no transfer
    s0 = n_starts;
    send3(8'h00, 8'h00, 8'h00);
    recv_byte(b); chk("len0_status", b, 8'h02);
    send3(8'h08, 8'h56, 8'h78);
    recv_byte(b); chk("len8_status", b, 8'h02);
    chk("len8_addr", transfer_address, 16'h5678);
    repeat (3) @(negedge clk_i);
    chk("badlen_no_start", n_starts, s0);
    chk("badlen_no_more_tx", tx_valid, 1'b0);

    // Master timeout on a read: status 01 only
    send3(8'h02, 8'h00, 8'h20);
    wait_start();
    chk("to_kind", {start_read, start_write}, 2'b10);
    master_run(1'b1);
    recv_byte(b); chk("to_status", b, 8'h01);
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (tx_valid) stable = 1'b0;
    end
    chk("to_no_data", stable, 1'b1);
    chk("to_back_cmd", rx_ready, 1'b1);
    timeout = 1'b0;

    // Inter-byte timeout after one of four data bytes
    s0 = n_starts;
    send3(8'h84, 8'h00, 8'h00);
    send_byte(8'hAA);
    repeat (254) @(negedge clk_i);
    chk("abort_early", frame_error, 1'b0);
    @(negedge clk_i);
    chk("abort_pulse", frame_error, 1'b1);
    @(negedge clk_i);
    chk("abort_one_cycle", frame_error, 1'b0);
    chk("abort_cmd", rx_ready, 1'b1);
    chk("abort_no_start", n_starts, s0);
    chk("abort_no_tx", tx_valid, 1'b0);
    send3(8'h0F, 8'h00, 8'h00);
    recv_byte(b); chk("after_abort_status", b, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
